pipe_hazard_ctrl: RTL and testbench

Parametrised hazard controller for the in-order MIPS pipeline: it generalises the fixed two-source forwarding unit and the load-use hazard detector into one block. It tracks in-flight destination registers across a configurable number of post-decode stages and a configurable load latency. It drives the EX operand forwarding selects, the decode stall, and a branch-taken flush. It sits beside the ID/EX pipeline register and is fed by decode and by the EX-stage branch comparator.

---
 rtl/pipe_hazard_pkg.sv | 38 +++
 rtl/pipe_hazard_match.sv | 36 +++
 rtl/pipe_hazard_ctrl.sv | 150 +++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Holds the per-stage tracking slot, the register-file forward code and
// parameter-legality helpers used at elaboration of pipe_hazard_ctrl.
package pipe_hazard_pkg;

   // Widest register index supported; narrower indices are zero-extended
   // into the slot so one struct type serves every REG_AW.
   localparam int REG_AW_MAX = 8;

   // Forward select value meaning "take the operand from the register file".
   localparam int FWD_RF = 0;

   typedef struct packed {
      logic                  valid;
      logic [REG_AW_MAX-1:0] rs;
      logic [REG_AW_MAX-1:0] rt;
      logic                  rs_used;
      logic                  rt_used;
      logic [REG_AW_MAX-1:0] dst;
      logic                  wr_en;
      logic                  is_load;
   } slot_t;

   function automatic bit depth_ok(input int depth);
      return (depth >= 3) && (depth <= 8);
   endfunction

   // Load data must become forwardable before the entry leaves the tracked
   // window, so the latency is capped at DEPTH-2.
   function automatic bit load_lat_ok(input int depth, input int lat);
      return (lat >= 1) && (lat <= depth - 2);
   endfunction

   function automatic bit reg_aw_ok(input int aw);
      return (aw >= 1) && (aw <= REG_AW_MAX);
   endfunction

endpackage

// File: rtl/pipe_hazard_match.sv
// Priority encoder: finds the youngest in-flight producer of one source register.
// Scans slots LO..HI; the lowest matching index wins. Register 0 never matches.
// Ports: slot (tracked stages), src/used (source to look up),
//        hit/idx/is_load (match flag, youngest slot index, that slot's load flag).
module pipe_hazard_match
   import pipe_hazard_pkg::*;
#(
   parameter int DEPTH = 3,
   parameter int LO    = 0,
   parameter int HI    = DEPTH - 1,
   parameter int IW    = $clog2(DEPTH)
) (
   input  slot_t                 slot [DEPTH],
   input  logic [REG_AW_MAX-1:0] src,
   input  logic                  used,
   output logic                  hit,
   output logic [IW-1:0]         idx,
   output logic                  is_load
);

   always_comb begin
      hit     = 1'b0;
      idx     = '0;
      is_load = 1'b0;
      // Walk from oldest to youngest so the youngest match overwrites.
      for (int k = HI; k >= LO; k--) begin
         if (used && (src != '0) && slot[k].valid && slot[k].wr_en &&
             (slot[k].dst == src)) begin
            hit     = 1'b1;
            idx     = IW'(k);
            is_load = slot[k].is_load;
         end
      end
   end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard controller for the in-order pipeline: tracks in-flight destinations
// over DEPTH post-decode stages (slot 0 = EX .. DEPTH-1 = WB) and drives the
// EX forward selects, the load-use decode stall and the branch-taken flush.
// Ports: clk/rst (sync active-high), id_* (decode instruction), ex_branch_taken,
//        stall, flush, fwd_sel_a/b (0 = register file, k = result of slot k).
// Optional: define PIPE_HAZARD_PERF_EN to add 32-bit wrapping stall/flush
//        cycle counters perf_stall_cnt / perf_flush_cnt.
module pipe_hazard_ctrl
   import pipe_hazard_pkg::*;
#(
   parameter int DEPTH    = 3,
   parameter int REG_AW   = 5,
   parameter int LOAD_LAT = 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     id_valid,
   input  logic [REG_AW-1:0]        id_rs,
   input  logic [REG_AW-1:0]        id_rt,
   input  logic                     id_rs_used,
   input  logic                     id_rt_used,
   input  logic [REG_AW-1:0]        id_dst,
   input  logic                     id_wr_en,
   input  logic                     id_is_load,
   input  logic                     ex_branch_taken,
   output logic                     stall,
   output logic                     flush,
   output logic [$clog2(DEPTH)-1:0] fwd_sel_a,
   output logic [$clog2(DEPTH)-1:0] fwd_sel_b
`ifdef PIPE_HAZARD_PERF_EN
   ,
   output logic [31:0]              perf_stall_cnt,
   output logic [31:0]              perf_flush_cnt
`endif
);

   localparam int IW = $clog2(DEPTH);
   // A load in slot j is still too young for the ID reader while j < LOAD_LAT,
   // and too young to forward to EX while k < LOAD_LAT+1.
   localparam logic [IW-1:0] LAT_IDX = IW'(LOAD_LAT);
   localparam logic [IW-1:0] FWD_MIN = IW'(LOAD_LAT + 1);
   localparam logic [IW-1:0] SEL_RF  = IW'(FWD_RF);

   if (!depth_ok(DEPTH) || !load_lat_ok(DEPTH, LOAD_LAT) || !reg_aw_ok(REG_AW)) begin : g_bad_params
      $error("pipe_hazard_ctrl: illegal DEPTH/LOAD_LAT/REG_AW combination");
   end

   slot_t slot [DEPTH];
   slot_t id_ent;

   always_comb begin
      id_ent         = '0;
      id_ent.valid   = 1'b1;
      id_ent.rs      = REG_AW_MAX'(id_rs);
      id_ent.rt      = REG_AW_MAX'(id_rt);
      id_ent.rs_used = id_rs_used;
      id_ent.rt_used = id_rt_used;
      id_ent.dst     = REG_AW_MAX'(id_dst);
      id_ent.wr_en   = id_wr_en;
      id_ent.is_load = id_is_load;
   end

   // ---------------- EX operand forwarding (consumer in slot 0) ----------------
   logic          ex_a_hit, ex_a_load, ex_b_hit, ex_b_load;
   logic [IW-1:0] ex_a_idx, ex_b_idx;

   pipe_hazard_match #(.DEPTH(DEPTH), .LO(1), .HI(DEPTH-1), .IW(IW)) u_match_ex_a (
      .slot    (slot),
      .src     (slot[0].rs),
      .used    (slot[0].valid & slot[0].rs_used),
      .hit     (ex_a_hit),
      .idx     (ex_a_idx),
      .is_load (ex_a_load)
   );

   pipe_hazard_match #(.DEPTH(DEPTH), .LO(1), .HI(DEPTH-1), .IW(IW)) u_match_ex_b (
      .slot    (slot),
      .src     (slot[0].rt),
      .used    (slot[0].valid & slot[0].rt_used),
      .hit     (ex_b_hit),
      .idx     (ex_b_idx),
      .is_load (ex_b_load)
   );

   // A too-young load as the youngest match falls back to the register file;
   // the decode stall keeps that case from arising.
   logic ex_a_ok, ex_b_ok;
   assign ex_a_ok = ex_a_hit & ~(ex_a_load & (ex_a_idx < FWD_MIN));
   assign ex_b_ok = ex_b_hit & ~(ex_b_load & (ex_b_idx < FWD_MIN));

   assign fwd_sel_a = (rst | ~ex_a_ok) ? SEL_RF : ex_a_idx;
   assign fwd_sel_b = (rst | ~ex_b_ok) ? SEL_RF : ex_b_idx;

   // ---------------- Load-use detection (consumer in ID) ----------------
   // WB (slot DEPTH-1) is excluded: the register file writes before ID reads.
   logic          id_a_hit, id_a_load, id_b_hit, id_b_load;
   logic [IW-1:0] id_a_idx, id_b_idx;

   pipe_hazard_match #(.DEPTH(DEPTH), .LO(0), .HI(DEPTH-2), .IW(IW)) u_match_id_rs (
      .slot    (slot),
      .src     (id_ent.rs),
      .used    (id_valid & id_rs_used),
      .hit     (id_a_hit),
      .idx     (id_a_idx),
      .is_load (id_a_load)
   );

   pipe_hazard_match #(.DEPTH(DEPTH), .LO(0), .HI(DEPTH-2), .IW(IW)) u_match_id_rt (
      .slot    (slot),
      .src     (id_ent.rt),
      .used    (id_valid & id_rt_used),
      .hit     (id_b_hit),
      .idx     (id_b_idx),
      .is_load (id_b_load)
   );

   logic raw_stall;
   assign raw_stall = (id_a_hit & id_a_load & (id_a_idx < LAT_IDX)) |
                      (id_b_hit & id_b_load & (id_b_idx < LAT_IDX));

   // A taken branch squashes the stalled instruction, so flush wins.
   assign flush = ex_branch_taken & ~rst;
   assign stall = raw_stall & ~ex_branch_taken & ~rst;

   // ---------------- Slot shift register ----------------
   logic slot_ld;
   assign slot_ld = id_valid & ~stall & ~flush;

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < DEPTH; k++) slot[k] <= '0;
      end else begin
         slot[0] <= slot_ld ? id_ent : '0;
         for (int k = 1; k < DEPTH; k++) slot[k] <= slot[k-1];
      end
   end

`ifdef PIPE_HAZARD_PERF_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         perf_stall_cnt <= '0;
         perf_flush_cnt <= '0;
      end else begin
         if (stall) perf_stall_cnt <= perf_stall_cnt + 32'd1;
         if (flush) perf_flush_cnt <= perf_flush_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: instance a (DEPTH=3, LOAD_LAT=1) and
// instance b (DEPTH=5, LOAD_LAT=2). Inputs change 2 time units after each
// rising edge and outputs are checked 1 unit later, well clear of the edges.
module tb_pipe_hazard_ctrl;

   logic clk;
   logic rst;

   logic       a_valid, a_rsu, a_rtu, a_wr, a_ld, a_br;
   logic [4:0] a_rs, a_rt, a_dst;
   logic       a_stall, a_flush;
   logic [1:0] a_fa, a_fb;

   logic       b_valid, b_rsu, b_rtu, b_wr, b_ld, b_br;
   logic [4:0] b_rs, b_rt, b_dst;
   logic       b_stall, b_flush;
   logic [2:0] b_fa, b_fb;

`ifdef PIPE_HAZARD_PERF_EN
   logic [31:0] a_pstall, a_pflush, b_pstall, b_pflush;
`endif

   int vectors    = 0;
   int miscompares = 0;

   pipe_hazard_ctrl #(.DEPTH(3), .REG_AW(5), .LOAD_LAT(1)) u_a (
      .clk (clk), .rst (rst),
      .id_valid (a_valid), .id_rs (a_rs), .id_rt (a_rt),
      .id_rs_used (a_rsu), .id_rt_used (a_rtu), .id_dst (a_dst),
      .id_wr_en (a_wr), .id_is_load (a_ld), .ex_branch_taken (a_br),
      .stall (a_stall), .flush (a_flush), .fwd_sel_a (a_fa), .fwd_sel_b (a_fb)
`ifdef PIPE_HAZARD_PERF_EN
      , .perf_stall_cnt (a_pstall), .perf_flush_cnt (a_pflush)
`endif
   );

   pipe_hazard_ctrl #(.DEPTH(5), .REG_AW(5), .LOAD_LAT(2)) u_b (
      .clk (clk), .rst (rst),
      .id_valid (b_valid), .id_rs (b_rs), .id_rt (b_rt),
      .id_rs_used (b_rsu), .id_rt_used (b_rtu), .id_dst (b_dst),
      .id_wr_en (b_wr), .id_is_load (b_ld), .ex_branch_taken (b_br),
      .stall (b_stall), .flush (b_flush), .fwd_sel_a (b_fa), .fwd_sel_b (b_fb)
`ifdef PIPE_HAZARD_PERF_EN
      , .perf_stall_cnt (b_pstall), .perf_flush_cnt (b_pflush)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp)
      else begin
         miscompares++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic set_a(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                        input logic rsu, input logic rtu, input logic [4:0] dst,
                        input logic wr, input logic ld);
      a_valid = v; a_rs = rs; a_rt = rt; a_rsu = rsu; a_rtu = rtu;
      a_dst = dst; a_wr = wr; a_ld = ld;
   endtask

   task automatic set_b(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                        input logic rsu, input logic rtu, input logic [4:0] dst,
                        input logic wr, input logic ld);
      b_valid = v; b_rs = rs; b_rt = rt; b_rsu = rsu; b_rtu = rtu;
      b_dst = dst; b_wr = wr; b_ld = ld;
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #2;
   endtask

   initial begin
      // Reset with a live instruction and a taken branch on the inputs.
      rst = 1'b1; a_br = 1'b1; b_br = 1'b1;
      set_a(1, 5'd1, 5'd2, 1, 1, 5'd3, 1, 0);   // add $3,$1,$2
      set_b(1, 5'd1, 5'd2, 1, 1, 5'd3, 1, 0);
      @(posedge clk); #3;
      chk("rst_stall_a", 32'(a_stall), 0);
      chk("rst_flush_a", 32'(a_flush), 0);
      chk("rst_fa_a",    32'(a_fa), 0);
      chk("rst_fb_a",    32'(a_fb), 0);
      chk("rst_flush_b", 32'(b_flush), 0);
      @(posedge clk); #3;
      chk("rst2_stall_a", 32'(a_stall), 0);

      // C1: release reset; add $3,$1,$2 in ID.
      next_cycle();
      rst = 1'b0; a_br = 1'b0; b_br = 1'b0;
      set_b(0, 0, 0, 0, 0, 0, 0, 0);
      #1;
      chk("c1_stall", 32'(a_stall), 0);
      chk("c1_flush", 32'(a_flush), 0);
`ifdef PIPE_HAZARD_PERF_EN
      chk("c1_pstall", a_pstall, 0);
      chk("c1_pflush", a_pflush, 0);
`endif
      // C2: sub $4,$3,$5 while add is in EX.
      next_cycle();
      set_a(1, 5'd3, 5'd5, 1, 1, 5'd4, 1, 0);
      #1;
      chk("alu_dep_stall", 32'(a_stall), 0);
      chk("add_ex_fa", 32'(a_fa), 0);
      // C3: sub in EX, add in slot 1.
      next_cycle();
      set_a(0, 0, 0, 0, 0, 0, 0, 0);
      #1;
      chk("sub_ex_fa", 32'(a_fa), 1);
      chk("sub_ex_fb", 32'(a_fb), 0);
      // C4: bubble in EX; or $7,$3,$4 in ID.
      next_cycle();
      set_a(1, 5'd3, 5'd4, 1, 1, 5'd7, 1, 0);
      #1;
      chk("bubble_fa", 32'(a_fa), 0);
      chk("or_id_stall", 32'(a_stall), 0);
      // C5: or in EX; add already dropped, sub in WB slot 2.
      next_cycle();
      set_a(1, 5'd1, 5'd0, 1, 0, 5'd9, 1, 0);   // addi $9,$1
      #1;
      chk("or_ex_fa_dropped", 32'(a_fa), 0);
      chk("or_ex_fb_slot2",   32'(a_fb), 2);
      // C6: second addi $9.
      next_cycle();
      set_a(1, 5'd1, 5'd0, 1, 0, 5'd9, 1, 0);
      #1;
      // C7: reader of $9 (rt not used).
      next_cycle();
      set_a(1, 5'd9, 5'd9, 1, 0, 5'd11, 1, 0);
      #1;
      chk("dual_wr_stall", 32'(a_stall), 0);
      // C8: reader in EX; younger addi must win. lw $2,0($1) in ID.
      next_cycle();
      set_a(1, 5'd1, 5'd0, 1, 0, 5'd2, 1, 1);
      #1;
      chk("youngest_fa", 32'(a_fa), 1);
      chk("unused_rt_fb", 32'(a_fb), 0);
      chk("lw_id_stall", 32'(a_stall), 0);
      // C9: add $6,$2,$7 with lw in EX -> stall.
      next_cycle();
      set_a(1, 5'd2, 5'd7, 1, 1, 5'd6, 1, 0);
      #1;
      chk("lu_stall_1", 32'(a_stall), 1);
      // C10: held in ID, lw in slot 1 -> released.
      next_cycle();
      #1;
      chk("lu_stall_2", 32'(a_stall), 0);
      chk("lu_bubble_fa", 32'(a_fa), 0);
      // C11: add in EX, lw in slot 2.
      next_cycle();
      set_a(0, 0, 0, 0, 0, 0, 0, 0);
      #1;
      chk("lu_fa", 32'(a_fa), 2);
      chk("lu_fb", 32'(a_fb), 0);
      // C12: lw $0,0($1).
      next_cycle();
      set_a(1, 5'd1, 5'd0, 1, 0, 5'd0, 1, 1);
      #1;
      // C13: add $5,$0,$0.
      next_cycle();
      set_a(1, 5'd0, 5'd0, 1, 1, 5'd5, 1, 0);
      #1;
      chk("r0_stall", 32'(a_stall), 0);
      chk("r0_lw_fa", 32'(a_fa), 0);
      // C14: reader of $0 in EX, lw $0 in slot 1.
      next_cycle();
      set_a(0, 0, 0, 0, 0, 0, 0, 0);
      #1;
      chk("r0_fa", 32'(a_fa), 0);
      chk("r0_fb", 32'(a_fb), 0);
      // C15: lw $4,0($1).
      next_cycle();
      set_a(1, 5'd1, 5'd0, 1, 0, 5'd4, 1, 1);
      #1;
      // C16: add $10,$4,$4 load-use plus taken branch.
      next_cycle();
      set_a(1, 5'd4, 5'd4, 1, 1, 5'd10, 1, 0);
      a_br = 1'b1;
      #1;
      chk("br_lu_flush", 32'(a_flush), 1);
      chk("br_lu_stall", 32'(a_stall), 0);
      // C17: reader of $10 and $4; squashed add must not be tracked.
      next_cycle();
      a_br = 1'b0;
      set_a(1, 5'd10, 5'd4, 1, 1, 5'd12, 1, 0);
      #1;
      chk("post_br_flush", 32'(a_flush), 0);
      chk("post_br_stall", 32'(a_stall), 0);
      // C18: reader in EX, flush bubble in slot 1, lw $4 in slot 2.
      next_cycle();
      set_a(0, 0, 0, 0, 0, 0, 0, 0);
      #1;
      chk("squashed_fa", 32'(a_fa), 0);
      chk("post_br_fb",  32'(a_fb), 2);
`ifdef PIPE_HAZARD_PERF_EN
      chk("perf_stall_a", a_pstall, 1);
      chk("perf_flush_a", a_pflush, 1);
`endif

      // ---- DEPTH=5, LOAD_LAT=2 ----
      next_cycle();
      set_b(1, 5'd1, 5'd0, 1, 0, 5'd2, 1, 1);   // lw $2,0($1)
      #1;
      chk("b_lw_stall", 32'(b_stall), 0);
      next_cycle();
      set_b(1, 5'd2, 5'd7, 1, 1, 5'd6, 1, 0);   // add $6,$2,$7
      #1;
      chk("b_lu_stall_1", 32'(b_stall), 1);
      next_cycle();
      #1;
      chk("b_lu_stall_2", 32'(b_stall), 1);
      next_cycle();
      #1;
      chk("b_lu_stall_3", 32'(b_stall), 0);
      next_cycle();
      set_b(0, 0, 0, 0, 0, 0, 0, 0);
      #1;
      chk("b_lu_fa", 32'(b_fa), 3);
      chk("b_lu_fb", 32'(b_fb), 0);
      next_cycle();
      set_b(1, 5'd1, 5'd0, 1, 0, 5'd3, 1, 1);   // lw $3,0($1)
      #1;
      next_cycle();
      set_b(1, 5'd3, 5'd0, 1, 0, 5'd8, 1, 0);   // reader of $3
      #1;
      chk("b_mid_stall", 32'(b_stall), 1);
`ifdef PIPE_HAZARD_PERF_EN
      chk("perf_stall_b", b_pstall, 2);
`endif
      // Reset during the pending stall.
      next_cycle();
      rst = 1'b1;
      #1;
      chk("b_rst_stall", 32'(b_stall), 0);
      next_cycle();
      rst = 1'b0;
      #1;
      chk("b_abandon_stall", 32'(b_stall), 0);
`ifdef PIPE_HAZARD_PERF_EN
      chk("perf_clr_b", b_pstall, 0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
